// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, FAULT} state_t;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] EBASE    = 32'h0000_4180;
    localparam logic [31:0] TEXT_LO  = 32'h0000_3000;
    localparam logic [31:0] TEXT_HI  = 32'h0000_6ffc;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } entry_t;

    function automatic logic adel_chk(input logic [31:0] addr);
        return (addr < TEXT_LO) || (addr > TEXT_HI) || (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/acknowledge handshake.
interface fetch_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_skid.sv
// One-entry skid buffer; on a branch it keeps its entry only if it is the delay slot.
module fetch_skid
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  entry_t      load_entry,
    input  logic        drain,
    input  logic        flush,
    input  logic        keep_en,
    input  logic [31:0] keep_pc,
    output logic        valid,
    output entry_t      entry
);

    logic   valid_d;
    entry_t entry_d;

    always_comb begin
        valid_d = valid;
        entry_d = entry;
        if (load) begin
            valid_d = 1'b1;
            entry_d = load_entry;
        end else if (drain) begin
            valid_d = 1'b0;
        end
        if (flush || (keep_en && entry_d.pc != keep_pc))
            valid_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            entry <= '{pc: RESET_PC, instr: NOP, adel: 1'b0};
        end else begin
            valid <= valid_d;
            entry <= entry_d;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// PC owner and instruction-memory requester feeding the F/D boundary through
// an output register plus skid buffer; handles branch/exception/eret redirects.
module fetch_sequencer
    import fetch_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall,
    input  logic                      br_valid,
    input  logic [31:0]               br_pc,
    input  logic [31:0]               br_target,
    input  logic                      exc_req,
    input  logic                      eret_req,
    input  logic [31:0]               epc,
    fetch_sequencer_if.master         imem,
    output logic                      if_valid,
    output logic [31:0]               if_pc,
    output logic [31:0]               if_instr,
    output logic                      if_adel
);

    state_t      state, state_d;
    logic [31:0] pc, pc_d, pend_target, pend_target_d, addr_d, slot_pc;
    logic        pend, pend_d, kill, kill_d, req_d;
    logic        out_valid, out_valid_d;
    entry_t      out, out_d, ack_entry, skid_entry;
    logic        skid_valid, skid_load, flush_all;
    logic        consume, slot_free, ack, br, redirect, slot_inflight;
    logic        discard, deliver, can_issue, adel, issue, inject;

    assign consume       = out_valid && !stall;
    assign slot_free     = !out_valid || consume;
    assign ack           = (state == BUSY) && imem.imem_ack;
    assign flush_all     = exc_req || eret_req;
    assign br            = br_valid && !flush_all;
    assign redirect      = flush_all || br_valid;
    assign slot_pc       = br_pc + 32'd4;
    assign slot_inflight = br && (imem.imem_addr == slot_pc);
    // Data of an acknowledged request survives only if not killed and not younger than a new redirect
    assign discard       = kill || (redirect && !slot_inflight);
    assign deliver       = ack && !discard;
    assign can_issue     = !skid_valid && slot_free && !redirect;
    assign adel          = adel_chk(pc);
    // A faulting pc is injected only from IDLE so it never collides with delivered data
    assign issue         = can_issue && !adel && ((state == IDLE) || deliver);
    assign inject        = can_issue && adel && (state == IDLE);
    assign skid_load     = deliver && !slot_free;
    assign ack_entry     = '{pc: imem.imem_addr, instr: imem.imem_rdata, adel: 1'b0};

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        if (redirect) begin
            state_d = (state == BUSY && !ack) ? BUSY : IDLE;
        end else begin
            case (state)
                IDLE:    if (issue) state_d = BUSY; else if (inject) state_d = FAULT;
                BUSY:    if (ack) state_d = issue ? BUSY : IDLE;
                FAULT:   state_d = FAULT;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        pc_d          = pc;
        pend_d        = pend;
        pend_target_d = pend_target;
        kill_d        = kill;
        addr_d        = imem.imem_addr;
        if (ack) kill_d = 1'b0;
        if (redirect && state == BUSY && !ack && !slot_inflight) kill_d = 1'b1;

        if (exc_req) begin
            pc_d   = EBASE;
            pend_d = 1'b0;
        end else if (eret_req) begin
            pc_d   = epc;
            pend_d = 1'b0;
        end else if (br) begin
            // Delay slot not yet issued: fetch it first, then jump
            if (pc == slot_pc) begin
                pend_d        = 1'b1;
                pend_target_d = br_target;
            end else begin
                pc_d   = br_target;
                pend_d = 1'b0;
            end
        end else if (issue) begin
            addr_d = pc;
            pc_d   = pend ? pend_target : pc + 32'd4;
            pend_d = 1'b0;
        end
        req_d = (state_d == BUSY);

        out_d       = out;
        out_valid_d = out_valid;
        if (inject) begin
            out_valid_d = 1'b1;
            out_d       = '{pc: pc, instr: NOP, adel: 1'b1};
        end else if (slot_free) begin
            if (skid_valid) begin
                out_valid_d = 1'b1;
                out_d       = skid_entry;
            end else if (deliver) begin
                out_valid_d = 1'b1;
                out_d       = ack_entry;
            end else begin
                out_valid_d = 1'b0;
            end
        end
        if (flush_all || (br && out_d.pc != slot_pc)) out_valid_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc             <= RESET_PC;
            pend           <= 1'b0;
            pend_target    <= RESET_PC;
            kill           <= 1'b0;
            imem.imem_req  <= 1'b0;
            imem.imem_addr <= RESET_PC;
            out_valid      <= 1'b0;
            out            <= '{pc: RESET_PC, instr: NOP, adel: 1'b0};
        end else begin
            pc             <= pc_d;
            pend           <= pend_d;
            pend_target    <= pend_target_d;
            kill           <= kill_d;
            imem.imem_req  <= req_d;
            imem.imem_addr <= addr_d;
            out_valid      <= out_valid_d;
            out            <= out_d;
        end
    end

    fetch_skid u_skid (
        .clk        (clk),
        .reset      (reset),
        .load       (skid_load),
        .load_entry (ack_entry),
        .drain      (slot_free),
        .flush      (flush_all),
        .keep_en    (br),
        .keep_pc    (slot_pc),
        .valid      (skid_valid),
        .entry      (skid_entry)
    );

    assign if_valid = out_valid;
    assign if_pc    = out.pc;
    assign if_instr = out.instr;
    assign if_adel  = out.adel;

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch sequencer that owns the program counter and drives the instruction-memory request/acknowledge handshake. It delivers `{pc, instr}` entries to the F/D boundary through a one-entry output register backed by a one-entry skid buffer. It arbitrates among sequential fetch, branch redirect (MIPS delay-slot semantics), exception entry and `eret`. It detects fetch address errors (AdEL) and injects them as faulting entries instead of issuing them to memory.

## Interface
- `RESET_PC`, 32'h0000_3000, PC after reset
- `EBASE`, 32'h0000_4180, exception entry address
- `TEXT_LO`, 32'h0000_3000, lowest legal fetch address
- `TEXT_HI`, 32'h0000_6ffc, highest legal fetch address

- `clk` in 1: clock
- `reset` in 1: reset, synchronous, active-high
- `stall` in 1: D stage cannot accept the current output entry
- `br_valid` in 1: one-cycle branch/jump redirect from D
- `br_pc` in 32: address of the redirecting branch
- `br_target` in 32: redirect target
- `exc_req` in 1: CP0 exception/interrupt request
- `eret_req` in 1: `eret` commit
- `epc` in 32: return address for `eret`
- `imem_req` out 1: fetch request, registered
- `imem_addr` out 32: fetch address, registered
- `imem_ack` in 1: fetch complete; `imem_rdata` valid this cycle
- `imem_rdata` in 32: fetched word
- `if_valid` out 1: output entry valid
- `if_pc` out 32: entry address
- `if_instr` out 32: entry word (32'h0 when `if_adel` is set)
- `if_adel` out 1: entry is a fetch address error

## Operation
- States: IDLE (no outstanding request), BUSY (request outstanding), FAULT (AdEL emitted, fetching halted).
- Consume: `if_valid && !stall` at a clock edge. Slot free: `!if_valid` or consume.
- Skid buffer: an `imem_ack` arriving while the slot is not free loads the skid buffer. When the slot frees, the skid entry moves to the output. No request is issued while the skid buffer is full.
- Issue (IDLE, or BUSY with `imem_ack`): requires skid empty, slot free and no redirect this cycle. Sets `imem_req`=1 and `imem_addr`=pc, then pc += 4.
- AdEL check: pc < `TEXT_LO`, pc > `TEXT_HI`, or `pc[1:0]` != 0. When the check fires at the point a request would issue, nothing goes to memory. Instead the entry `{pc, 0, adel=1}` enters the output and the state becomes FAULT. Only a redirect leaves FAULT.
- Handshake: `imem_req` and `imem_addr` stay stable from issue until `imem_ack`. The request is never withdrawn except by `reset`.
- Redirect priority: `reset` > `exc_req` > `eret_req` > `br_valid`.
- `exc_req` / `eret_req`:
  - Flush the output register and the skid buffer.
  - If BUSY, set `kill`; the acknowledged data is discarded.
  - pc <= `EBASE` / `epc`; state leaves FAULT.
- `br_valid`: the only entry retained is the delay slot (address `br_pc`+4), wherever it sits: output register, skid buffer or in flight. All younger entries are flushed or killed.
  - If the delay slot has not yet issued (pc == `br_pc`+4), set `pend` and store the target. pc jumps to `pend_target` right after the slot issues.
  - Otherwise pc <= `br_target`.
- A killed request still completes its handshake. The cycle of its `imem_ack` issues no new request; the next issue happens the following cycle.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `if_valid`=0, `if_pc`=`RESET_PC`, `if_instr`=0, `if_adel`=0, state IDLE, `kill`=`pend`=0, skid empty.
- First cycle after reset release: IDLE issues; `imem_req`=1 and `imem_addr`=`RESET_PC` appear one cycle later.
- Zero-wait memory (`imem_ack` in the first request cycle), no stall: `if_valid` rises one edge after the ack, sustaining 1 entry/cycle.
- Redirect to first new request: 1 cycle from IDLE. From BUSY: 1 cycle after the killed ack.
- Redirect coinciding with `imem_ack`: the kill and retention rules apply to that same ack.
- Reset during BUSY: `imem_req` drops at the reset edge. The memory model tolerates the abandoned request.

## Structure
- Shared package `fetch_pkg`: the state enum (IDLE/BUSY/FAULT), `RESET_PC`, `EBASE`, `TEXT_LO`, `TEXT_HI`, the NOP constant, and the `{pc, instr, adel}` entry struct.
- One sub-module, `fetch_skid`: a one-entry skid buffer with load/drain/flush plus a selective-keep compare against `br_pc`+4. The next-PC mux, priority logic and FSM stay in the top module.

## Test plan
- Reset, zero-wait memory, no stall: `imem_addr` = 0x3000, 0x3004, 0x3008 on consecutive cycles; `if_pc` follows one cycle behind; `if_adel`=0.
- `stall` held 3 cycles with a 1-wait memory: the skid buffer fills, issue pauses, the held entry stays stable, and no entry is lost or duplicated after release.
- Branch at 0x3010, target 0x3400, slot 0x3014 in the output register and 0x3018 in flight: 0x3018 is killed, the next request is 0x3400, and the delivered sequence is 0x3014, 0x3400.
- `exc_req` and `br_valid` in the same cycle, during BUSY: `exc_req` wins, output and skid are flushed, and the next request is 0x4180.
- `eret_req` with `epc` = 0x3002: no `imem_req`; entry `{0x3002, 0, adel=1}`; state FAULT until a subsequent `exc_req` issues 0x4180.
- Reset asserted in BUSY: next cycle `imem_req`=0 and `if_valid`=0; fetch restarts at 0x3000.
